// File: rtl/alu_ctrl.sv
// Multi-cycle 8/16-bit command ALU sequencer. One shared 8-bit ALU is stepped
// through the low byte, the high byte and an optional carry-increment of the high byte.

module alu8 (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [2:0] ALU_Sel,
   output logic [7:0] ALU_Out,
   output logic       CarryOut
);
   logic [8:0] wide_res;

   // For SUB, CarryOut is the borrow out of bit 7
   always_comb begin
      wide_res = 9'h000;
      ALU_Out  = 8'h00;
      CarryOut = 1'b0;
      case (ALU_Sel)
         3'b000: begin
            wide_res = {1'b0, A} + {1'b0, B};
            ALU_Out  = wide_res[7:0];
            CarryOut = wide_res[8];
         end
         3'b001: begin
            wide_res = {1'b0, A} - {1'b0, B};
            ALU_Out  = wide_res[7:0];
            CarryOut = wide_res[8];
         end
         3'b010:  ALU_Out = A & B;
         3'b011:  ALU_Out = A | B;
         3'b100:  ALU_Out = A ^ B;
         default: ALU_Out = 8'h00;
      endcase
   end
endmodule

module alu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic        cmd_wide,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_carry,
   output logic        rsp_err
);
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      INC  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t              state_q;
   logic [OP_W-1:0]     op_q;
   logic                wide_q;
   logic [BYTE_W-1:0]   a_hi_q;
   logic [BYTE_W-1:0]   b_hi_q;
   logic                c_lo_q;
   logic [BYTE_W-1:0]   alu_a_q;
   logic [BYTE_W-1:0]   alu_b_q;
   logic [OP_W-1:0]     alu_sel_q;
   logic                cmd_ready_q;
   logic                rsp_valid_q;
   logic [WORD_W-1:0]   rsp_data_q;
   logic                rsp_carry_q;
   logic                rsp_err_q;

   logic [BYTE_W-1:0]   alu_out;
   logic                alu_carry;
   logic                cmd_illegal_c;
   logic                op_arith_c;

   alu8 u_alu (
      .A        (alu_a_q),
      .B        (alu_b_q),
      .ALU_Sel  (alu_sel_q),
      .ALU_Out  (alu_out),
      .CarryOut (alu_carry)
   );

   // The single ALU has no carry-in, so wide SUB cannot be chained and is rejected
   assign cmd_illegal_c = (cmd_op > OP_XOR) || (cmd_wide && (cmd_op == OP_SUB));
   assign op_arith_c    = (op_q == OP_ADD) || (op_q == OP_SUB);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         wide_q      <= 1'b0;
         a_hi_q      <= '0;
         b_hi_q      <= '0;
         c_lo_q      <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  op_q        <= cmd_op;
                  wide_q      <= cmd_wide;
                  a_hi_q      <= cmd_a[15:8];
                  b_hi_q      <= cmd_b[15:8];
                  c_lo_q      <= 1'b0;
                  cmd_ready_q <= 1'b0;
                  if (cmd_illegal_c) begin
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_carry_q <= 1'b0;
                  end else begin
                     // ALU operands are registered, so the low bytes load on accept
                     state_q   <= LO;
                     alu_a_q   <= cmd_a[7:0];
                     alu_b_q   <= cmd_b[7:0];
                     alu_sel_q <= cmd_op;
                  end
               end
            end
            LO: begin
               rsp_data_q <= {8'h00, alu_out};
               c_lo_q     <= alu_carry;
               if (wide_q) begin
                  state_q <= HI;
                  alu_a_q <= a_hi_q;
                  alu_b_q <= b_hi_q;
               end else begin
                  state_q     <= DONE;
                  rsp_carry_q <= op_arith_c & alu_carry;
                  rsp_valid_q <= 1'b1;
                  alu_a_q     <= '0;
                  alu_b_q     <= '0;
                  alu_sel_q   <= '0;
               end
            end
            HI: begin
               rsp_data_q[15:8] <= alu_out;
               rsp_carry_q      <= (op_q == OP_ADD) & alu_carry;
               if ((op_q == OP_ADD) && c_lo_q) begin
                  // Propagate the low-byte carry by incrementing the high byte
                  state_q   <= INC;
                  alu_a_q   <= alu_out;
                  alu_b_q   <= 8'h01;
                  alu_sel_q <= OP_ADD;
               end else begin
                  state_q     <= DONE;
                  rsp_valid_q <= 1'b1;
                  alu_a_q     <= '0;
                  alu_b_q     <= '0;
                  alu_sel_q   <= '0;
               end
            end
            INC: begin
               rsp_data_q[15:8] <= alu_out;
               rsp_carry_q      <= rsp_carry_q | alu_carry;
               state_q          <= DONE;
               rsp_valid_q      <= 1'b1;
               alu_a_q          <= '0;
               alu_b_q          <= '0;
               alu_sel_q        <= '0;
            end
            DONE: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  cmd_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rsp_data_q  <= '0;
                  rsp_carry_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: results, latency, stall handling and mid-operation reset.

module tb_alu_ctrl;
   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic        cmd_wide;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_carry;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   alu_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_wide  (cmd_wide),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one command, measure accept-to-valid latency, check the response, retire it
   task automatic run_cmd(input string tag, input logic [2:0] op, input logic wide,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_data, input logic exp_carry,
                          input logic exp_err, input int exp_lat);
      int lat;
      @(negedge clk);
      check({tag, " ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_wide  = wide;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " data"},    32'(rsp_data), 32'(exp_data));
      check({tag, " carry"},   32'(rsp_carry), 32'(exp_carry));
      check({tag, " err"},     32'(rsp_err), 32'(exp_err));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check({tag, " retire valid"}, 32'(rsp_valid), 32'd0);
      check({tag, " retire ready"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      cmd_wide  = 1'b0;
      cmd_a     = 16'h0000;
      cmd_b     = 16'h0000;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_data",  32'(rsp_data),  32'd0);
      check("reset rsp_carry", 32'(rsp_carry), 32'd0);
      check("reset rsp_err",   32'(rsp_err),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_cmd("n_add",    3'b000, 1'b0, 16'h0015, 16'h000A, 16'h001F, 1'b0, 1'b0, 2);
      run_cmd("n_sub",    3'b001, 1'b0, 16'h0015, 16'h000A, 16'h000B, 1'b0, 1'b0, 2);
      run_cmd("n_add_hi", 3'b000, 1'b0, 16'hAB15, 16'hCD0A, 16'h001F, 1'b0, 1'b0, 2);
      run_cmd("n_add_c",  3'b000, 1'b0, 16'h00FF, 16'h00FF, 16'h00FE, 1'b1, 1'b0, 2);
      run_cmd("n_and",    3'b010, 1'b0, 16'h00F0, 16'h000F, 16'h0000, 1'b0, 1'b0, 2);
      run_cmd("w_add_inc",3'b000, 1'b1, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 4);
      run_cmd("w_add_ovf",3'b000, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 4);
      run_cmd("w_add",    3'b000, 1'b1, 16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0, 3);
      run_cmd("w_add_hc", 3'b000, 1'b1, 16'hF010, 16'h2020, 16'h1030, 1'b1, 1'b0, 3);
      run_cmd("w_xor",    3'b100, 1'b1, 16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0, 1'b0, 3);
      run_cmd("w_or",     3'b011, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 3);
      run_cmd("w_sub",    3'b001, 1'b1, 16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b1, 1);
      run_cmd("n_op7",    3'b111, 1'b0, 16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b1, 1);
      run_cmd("n_op5",    3'b101, 1'b0, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1);

      // Stall in DONE with a competing command held on the input
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'b011;
      cmd_wide  = 1'b0;
      cmd_a     = 16'h000F;
      cmd_b     = 16'h0030;
      @(posedge clk);
      #1;
      cmd_op = 3'b000;
      cmd_a  = 16'h0001;
      cmd_b  = 16'h0001;
      @(posedge clk);
      #1;
      check("stall valid", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("stall hold valid", 32'(rsp_valid), 32'd1);
         check("stall hold data",  32'(rsp_data),  32'h003F);
         check("stall hold carry", 32'(rsp_carry), 32'd0);
         check("stall hold ready", 32'(cmd_ready), 32'd0);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("stall release valid", 32'(rsp_valid), 32'd0);
      check("stall release ready", 32'(cmd_ready), 32'd1);

      // Reset while the high byte of a wide ADD is in flight
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'b000;
      cmd_wide  = 1'b1;
      cmd_a     = 16'h12FF;
      cmd_b     = 16'h0001;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("mid rst cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid rst rsp_data",  32'(rsp_data),  32'd0);
      check("mid rst rsp_carry", 32'(rsp_carry), 32'd0);
      check("mid rst rsp_err",   32'(rsp_err),   32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("mid rst no rsp", 32'(rsp_valid), 32'd0);
      end

      run_cmd("post_rst", 3'b000, 1'b1, 16'h00FF, 16'h0101, 16'h0200, 1'b0, 1'b0, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have no parameters; data widths are fixed at 8-bit ALU byte and 16-bit command operands.
REQ-002 The block SHALL have port clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-006 The block SHALL have port cmd_op, input, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101-111 illegal.
REQ-007 The block SHALL have port cmd_wide, input, 1 bit: 1 selects a 16-bit operation, 0 selects an 8-bit operation on the low bytes.
REQ-008 The block SHALL have ports cmd_a and cmd_b, input, 16 bits each: operands.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port rsp_data, output, 16 bits: result.
REQ-012 The block SHALL have port rsp_carry, output, 1 bit: carry/borrow flag.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: command rejected.

Function
REQ-014 The block SHALL instantiate the team's 8-bit ALU (ports A, B, ALU_Sel, ALU_Out, CarryOut) as its only arithmetic resource; for ADD, ALU_Out is sum[7:0] and CarryOut is sum[8].
REQ-015 The FSM SHALL have states IDLE, LO, HI, INC and DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1, and all operands and the op are captured into registers at that edge.
REQ-017 From IDLE on accept, the FSM SHALL go to DONE when the command is illegal, otherwise to LO.
- Illegal means op 101-111, or wide SUB.
REQ-018 LO SHALL drive the ALU with the low bytes and cmd_op, then register ALU_Out into result[7:0] and CarryOut into c_lo; it goes to DONE if narrow, otherwise to HI.
REQ-019 HI SHALL drive the ALU with the high bytes and cmd_op, then register result[15:8] and c_hi; it goes to INC if op=ADD and c_lo=1, otherwise to DONE.
REQ-020 INC SHALL drive the ALU with A=result[15:8], B=8'h01, ALU_Sel=ADD, then register result[15:8] and c_inc, and go to DONE.
REQ-021 DONE SHALL hold rsp_valid=1 with rsp_data, rsp_carry and rsp_err stable until rsp_ready=1, then go to IDLE on that edge.
REQ-022 Latency from the accept edge to the first rsp_valid cycle SHALL be: illegal 1; narrow 2; wide without INC 3; wide with INC 4.
REQ-023 Narrow results SHALL be zero-extended with rsp_data[15:8]=0.
REQ-024 rsp_carry SHALL be set as follows:
- Narrow ADD/SUB: c_lo.
- Wide ADD: c_hi OR c_inc.
- Logic ops: 0.
- Illegal: 0.
REQ-025 An illegal command SHALL produce rsp_err=1 and rsp_data=0; every legal command SHALL produce rsp_err=0.
REQ-026 Outside DONE, rsp_valid SHALL be 0; rsp_ready SHALL be ignored outside DONE, and cmd_valid SHALL be ignored outside IDLE.
REQ-027 Back-to-back operation SHALL be supported: the earliest next accept is the cycle after the DONE to IDLE transition, with no combinational path from rsp_ready to cmd_ready.
REQ-028 ALU input registers SHALL be held at 0 in IDLE and DONE.

Reset
REQ-029 When rst_n=0 at a rising edge, from any state including mid-operation, the block SHALL on the next cycle be in IDLE with cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_err=0, all internal registers 0, and the in-flight command discarded.
REQ-030 rst_n SHALL have priority over all other inputs.

Verification
REQ-031 Narrow ADD 0x15+0x0A SHALL give rsp_data=0x001F, carry 0, err 0, with rsp_valid 2 cycles after accept; narrow SUB 0x15-0x0A SHALL give 0x000B.
REQ-032 Narrow ADD 0xFF+0xFF SHALL give rsp_data=0x00FE with carry 1; narrow AND 0xF0&0x0F SHALL give 0x0000 with carry 0.
REQ-033 Wide ADD 0x12FF+0x0001 SHALL pass through LO, HI and INC, giving rsp_data=0x1300 with carry 0 at latency 4; wide ADD 0xFFFF+0x0001 SHALL give 0x0000 with carry 1.
REQ-034 Wide XOR 0xFF00^0x0FF0 SHALL give 0xF0F0 at latency 3; wide SUB and narrow op 111 SHALL each give err=1 and data=0 at latency 1.
REQ-035 Holding rsp_ready=0 for 3 cycles in DONE SHALL keep the outputs stable and cmd_ready=0, and cmd_valid held high meanwhile SHALL not be accepted; on rsp_ready=1, the state SHALL be IDLE the next cycle.
REQ-036 Asserting rst_n=0 for one edge while in HI of a wide ADD SHALL leave the block IDLE next cycle with all outputs 0, cmd_ready=1, and no response issued.
